// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage access unit: size codes, FSM states,
// the captured bus request and the lane helpers.
package mem_access_unit_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned RD_W  = 5;
    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // Everything needed to drive the bus and finish the instruction later
    typedef struct packed {
        logic            we;
        logic [XLEN-3:0] word_addr;
        logic [1:0]      lane;
        logic [1:0]      size;
        logic            is_unsigned;
        logic [RD_W-1:0] rd;
        logic            reg_write;
        logic [XLEN-1:0] wdata;
        logic [3:0]      byte_en;
    } mem_req_t;

    // Lane enables for an aligned access of the given size
    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 4'b0001 << lane;
            SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Store data replicated onto every lane it could land in
    function automatic logic [XLEN-1:0] replicate_wdata(input logic [1:0] size, input logic [XLEN-1:0] sd);
        case (size)
            SZ_BYTE: return {4{sd[7:0]}};
            SZ_HALF: return {2{sd[15:0]}};
            default: return sd;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load aligner: picks the addressed lane out of the read word and extends it.
module mem_access_unit_load_align
    import mem_access_unit_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      lane,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] value_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection and sign/zero extension
    always_comb begin
        case (lane)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: value_c = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            SZ_HALF: value_c = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            default: value_c = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: runs one req/ack data-memory transaction per load/store, aligns
// load data and emits a single write-back beat per accepted instruction.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [4:0]  rd_in,
    input  logic        reg_write_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_en,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        misalign,
    output logic        bus_timeout
);

    // Abort fires at the end of the TIMEOUT_CYCLES-th request cycle without ack
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    mem_req_t          req_q, req_nxt;

    logic              wb_valid_nxt, wb_reg_write_nxt, misalign_nxt, bus_timeout_nxt;
    logic [XLEN-1:0]   wb_data_nxt;
    logic [RD_W-1:0]   wb_rd_nxt;

    logic              accept, is_mem, misaligned, illegal, timeout_hit;
    logic [XLEN-1:0]   load_value_c;

    assign accept      = ex_valid && (state == ST_IDLE);
    assign is_mem      = mem_read | mem_write;
    assign illegal     = (mem_read & mem_write) | misaligned;
    assign timeout_hit = !mem_ack && (cnt == CNT_LIMIT);

    assign ex_ready    = (state == ST_IDLE);
    assign mem_req     = (state == ST_ACCESS);
    assign mem_we      = req_q.we;
    assign mem_addr    = {req_q.word_addr, 2'b00};
    assign mem_wdata   = req_q.wdata;
    assign mem_byte_en = req_q.byte_en;

    // Alignment rule per access size; reserved size always faults
    always_comb begin
        case (mem_size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = alu_result[0];
            SZ_WORD: misaligned = |alu_result[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    mem_access_unit_load_align u_load_align (
        .rdata       (mem_rdata),
        .lane        (req_q.lane),
        .size        (req_q.size),
        .is_unsigned (req_q.is_unsigned),
        .value_c     (load_value_c)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept && is_mem && !illegal) state_nxt = ST_ACCESS;
            ST_ACCESS: if (mem_ack || timeout_hit)       state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Output / capture logic: next values of the registered outputs
    always_comb begin
        req_nxt          = req_q;
        cnt_nxt          = cnt;
        wb_valid_nxt     = 1'b0;
        misalign_nxt     = 1'b0;
        bus_timeout_nxt  = 1'b0;
        wb_data_nxt      = wb_data;
        wb_rd_nxt        = wb_rd;
        wb_reg_write_nxt = wb_reg_write;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (!is_mem) begin
                        wb_valid_nxt     = 1'b1;
                        wb_data_nxt      = alu_result;
                        wb_rd_nxt        = rd_in;
                        wb_reg_write_nxt = reg_write_in;
                    end else if (illegal) begin
                        wb_valid_nxt     = 1'b1;
                        misalign_nxt     = 1'b1;
                        wb_data_nxt      = '0;
                        wb_rd_nxt        = rd_in;
                        wb_reg_write_nxt = 1'b0;
                    end else begin
                        req_nxt.we          = mem_write;
                        req_nxt.word_addr   = alu_result[31:2];
                        req_nxt.lane        = alu_result[1:0];
                        req_nxt.size        = mem_size;
                        req_nxt.is_unsigned = mem_unsigned;
                        req_nxt.rd          = rd_in;
                        req_nxt.reg_write   = reg_write_in;
                        req_nxt.wdata       = replicate_wdata(mem_size, store_data);
                        req_nxt.byte_en     = lane_enables(mem_size, alu_result[1:0]);
                        cnt_nxt             = '0;
                    end
                end
            end
            ST_ACCESS: begin
                if (mem_ack) begin
                    wb_valid_nxt     = 1'b1;
                    wb_rd_nxt        = req_q.rd;
                    wb_data_nxt      = req_q.we ? '0 : load_value_c;
                    wb_reg_write_nxt = req_q.we ? 1'b0 : req_q.reg_write;
                    cnt_nxt          = '0;
                end else if (timeout_hit) begin
                    wb_valid_nxt     = 1'b1;
                    bus_timeout_nxt  = 1'b1;
                    wb_rd_nxt        = req_q.rd;
                    wb_data_nxt      = '0;
                    wb_reg_write_nxt = 1'b0;
                    cnt_nxt          = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Registered outputs, captured request and timeout counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_q        <= '0;
            cnt          <= '0;
            wb_valid     <= 1'b0;
            misalign     <= 1'b0;
            bus_timeout  <= 1'b0;
            wb_data      <= '0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
        end else begin
            req_q        <= req_nxt;
            cnt          <= cnt_nxt;
            wb_valid     <= wb_valid_nxt;
            misalign     <= misalign_nxt;
            bus_timeout  <= bus_timeout_nxt;
            wb_data      <= wb_data_nxt;
            wb_rd        <= wb_rd_nxt;
            wb_reg_write <= wb_reg_write_nxt;
        end
    end

endmodule
